dta_ingr_rcv_responder: RTL and testbench

- Responder end of the ingress req/resp/data transfer protocol: accepts a 64-bit transfer request, grants a burst sized to the free receive-buffer credit, then accepts exactly the granted data beats and forwards them downstream.
- Sits opposite the ingress sender. Its resp/data streams must pass the ingress send protocol monitor with zero faults.

---
 rtl/dta_ingr_rcv_responder.sv | 170 +++++++++++++++++
 tb/tb_dta_ingr_rcv_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dta_ingr_rcv_responder.sv
// Ingress responder: grants bursts sized to free receive-buffer credit, then
// forwards exactly the granted data beats downstream.
module dta_ingr_rcv_responder #(
  parameter int unsigned BUF_BEATS       = 512,
  parameter int unsigned MAX_BURST_BEATS = 64
) (
  input  logic         ap_clk,
  input  logic         ap_rst_n,
  input  logic         req_tvalid,
  output logic         req_tready,
  input  logic [63:0]  req_tdata,
  output logic         resp_tvalid,
  input  logic         resp_tready,
  output logic [63:0]  resp_tdata,
  input  logic         data_tvalid,
  output logic         data_tready,
  input  logic [511:0] data_tdata,
  output logic         out_tvalid,
  input  logic         out_tready,
  output logic [511:0] out_tdata,
  output logic         out_tlast,
  output logic [15:0]  out_tuser,
  input  logic         credit_ret_valid,
  input  logic [10:0]  credit_ret_beats,
  output logic         err_zero_req,
  output logic         err_credit_ovf
);

  localparam logic [12:0] BufW = 13'(BUF_BEATS);
  localparam logic [12:0] MaxW = 13'(MAX_BURST_BEATS);

  typedef enum logic [1:0] {StIdle, StWait, StResp, StData} state_e;

  state_e      state_q, state_d;
  logic [15:0] ch_q, len_q;
  logic        sof_q, eof_q;
  logic [63:0] resp_q, resp_d;
  logic [12:0] free_q, free_d;
  logic [12:0] gbeats_q, gbeats_d;
  logic [12:0] cnt_q, cnt_d;
  logic        req_en_q;
  logic        err_zero_q, err_zero_d;
  logic        err_ovf_q, err_ovf_d;
  logic        req_load;

  logic [12:0] req_beats, grant_cap, grant_beats, reserve, credit_sum;
  logic [15:0] grant_len;

  // Grant sizing from the latched request and the current credit.
  always_comb begin
    req_beats = 13'((17'(len_q) + 17'd63) >> 6);
    grant_cap = (free_q < MaxW) ? free_q : MaxW;
    if (req_beats <= grant_cap) begin
      grant_len   = len_q;
      grant_beats = req_beats;
    end else begin
      grant_len   = 16'({grant_cap, 6'b0});
      grant_beats = grant_cap;
    end
  end

  always_comb begin
    state_d     = state_q;
    resp_d      = resp_q;
    gbeats_d    = gbeats_q;
    cnt_d       = cnt_q;
    err_zero_d  = err_zero_q;
    reserve     = 13'd0;
    req_load    = 1'b0;
    req_tready  = 1'b0;
    resp_tvalid = 1'b0;
    data_tready = 1'b0;
    out_tvalid  = 1'b0;
    out_tlast   = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_tready = req_en_q;
        if (req_tvalid && req_en_q) begin
          req_load = 1'b1;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (len_q == 16'd0) begin
          err_zero_d = 1'b1;
          gbeats_d   = 13'd0;
          resp_d     = {16'd0, 14'd0, eof_q, sof_q, 16'd0, ch_q};
          state_d    = StResp;
        end else if (free_q != 13'd0) begin
          reserve  = grant_beats;
          gbeats_d = grant_beats;
          resp_d   = {grant_len, 14'd0, eof_q, sof_q, 16'd0, ch_q};
          state_d  = StResp;
        end
      end
      StResp: begin
        resp_tvalid = 1'b1;
        if (resp_tready) begin
          if (gbeats_q == 13'd0) begin
            state_d = StIdle;
          end else begin
            cnt_d   = gbeats_q;
            state_d = StData;
          end
        end
      end
      StData: begin
        out_tvalid  = data_tvalid;
        data_tready = out_tready;
        out_tlast   = (cnt_q == 13'd1);
        if (data_tvalid && out_tready) begin
          cnt_d = cnt_q - 13'd1;
          if (cnt_q == 13'd1) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Return and reservation may coincide; apply both, then clamp.
  always_comb begin
    credit_sum = free_q - reserve + (credit_ret_valid ? 13'(credit_ret_beats) : 13'd0);
    err_ovf_d  = err_ovf_q;
    if (credit_sum > BufW) begin
      free_d    = BufW;
      err_ovf_d = 1'b1;
    end else begin
      free_d = credit_sum;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= StIdle;
      ch_q       <= '0;
      len_q      <= '0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      resp_q     <= '0;
      free_q     <= BufW;
      gbeats_q   <= '0;
      cnt_q      <= '0;
      req_en_q   <= 1'b0;
      err_zero_q <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      resp_q     <= resp_d;
      free_q     <= free_d;
      gbeats_q   <= gbeats_d;
      cnt_q      <= cnt_d;
      req_en_q   <= 1'b1;
      err_zero_q <= err_zero_d;
      err_ovf_q  <= err_ovf_d;
      if (req_load) begin
        ch_q  <= req_tdata[15:0];
        sof_q <= req_tdata[32];
        eof_q <= req_tdata[33];
        len_q <= req_tdata[63:48];
      end
    end
  end

  assign resp_tdata     = resp_q;
  assign out_tdata      = data_tdata;
  assign out_tuser      = ch_q;
  assign err_zero_req   = err_zero_q;
  assign err_credit_ovf = err_ovf_q;

endmodule

// File: tb/tb_dta_ingr_rcv_responder.sv
// Self-checking bench for dta_ingr_rcv_responder: directed table, stall/credit
// corner sequences, randomized transfers against a transaction-level model.
module tb_dta_ingr_rcv_responder;
  localparam int BUF  = 512;
  localparam int MAXB = 64;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n = 1'b0;
  logic         req_tvalid = 1'b0, req_tready;
  logic [63:0]  req_tdata = '0;
  logic         resp_tvalid, resp_tready = 1'b0;
  logic [63:0]  resp_tdata;
  logic         data_tvalid = 1'b0, data_tready;
  logic [511:0] data_tdata = '0;
  logic         out_tvalid, out_tready = 1'b0;
  logic [511:0] out_tdata;
  logic         out_tlast;
  logic [15:0]  out_tuser;
  logic         credit_ret_valid = 1'b0;
  logic [10:0]  credit_ret_beats = '0;
  logic         err_zero_req, err_credit_ovf;

  always #5 ap_clk = ~ap_clk;

  dta_ingr_rcv_responder #(.BUF_BEATS(BUF), .MAX_BURST_BEATS(MAXB)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata),
    .resp_tvalid(resp_tvalid), .resp_tready(resp_tready), .resp_tdata(resp_tdata),
    .data_tvalid(data_tvalid), .data_tready(data_tready), .data_tdata(data_tdata),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
    .out_tlast(out_tlast), .out_tuser(out_tuser),
    .credit_ret_valid(credit_ret_valid), .credit_ret_beats(credit_ret_beats),
    .err_zero_req(err_zero_req), .err_credit_ovf(err_credit_ovf)
  );

  int checks = 0;
  int errors = 0;
  int model_free = BUF;
  bit model_zero = 1'b0;
  bit model_ovf  = 1'b0;

  typedef struct {
    int len;
    int ch;
    bit sof;
    bit eof;
    int exp_len;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] rand_beat();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [63:0] word(input int len, input int ch, input bit sof, input bit eof);
    return {16'(len), 14'd0, eof, sof, 16'd0, 16'(ch)};
  endfunction

  // Grant length computed straight from the sizing rule on the modelled credit.
  function automatic int model_grant(input int len);
    int rb, gb;
    if (len == 0) return 0;
    rb = (len + 63) / 64;
    gb = (model_free < MAXB) ? model_free : MAXB;
    return (rb <= gb) ? len : gb * 64;
  endfunction

  task automatic send_req(input int len, input int ch, input bit sof, input bit eof);
    int guard = 0;
    req_tdata  = word(len, ch, sof, eof);
    req_tvalid = 1'b1;
    @(negedge ap_clk);
    while (!req_tready && guard < 50) begin
      @(posedge ap_clk); #1; guard++;
      @(negedge ap_clk);
    end
    chk("req_accept", 64'(guard < 50), 64'd1);
    @(posedge ap_clk); #1;
    req_tvalid = 1'b0;
    req_tdata  = {$urandom(), $urandom()};
  endtask

  task automatic get_resp(input bit chk_lat, input logic [63:0] exp_word);
    int lat = 0;
    logic [63:0] held;
    resp_tready = 1'b0;
    data_tvalid = 1'b1;
    out_tready  = 1'b1;
    @(negedge ap_clk);
    while (!resp_tvalid && lat < 100) begin
      chk("early_data_stall", {62'd0, data_tready, out_tvalid}, 64'd0);
      @(posedge ap_clk); #1; lat++;
      @(negedge ap_clk);
    end
    chk("resp_seen", 64'(resp_tvalid), 64'd1);
    if (chk_lat) chk("resp_latency", 64'(lat), 64'd1);
    chk("resp_word", resp_tdata, exp_word);
    held = resp_tdata;
    for (int k = 0; k < 3; k++) begin
      @(posedge ap_clk); #1;
      @(negedge ap_clk);
      chk("resp_hold_valid", 64'(resp_tvalid), 64'd1);
      chk("resp_hold_data", resp_tdata, held);
      chk("early_data_stall", {62'd0, data_tready, out_tvalid}, 64'd0);
    end
    @(posedge ap_clk); #1;
    resp_tready = 1'b1;
    @(negedge ap_clk);
    chk("resp_hs_valid", 64'(resp_tvalid), 64'd1);
    chk("resp_hs_data", resp_tdata, held);
    @(posedge ap_clk); #1;
    resp_tready = 1'b0;
    data_tvalid = 1'b0;
    chk("resp_drop", 64'(resp_tvalid), 64'd0);
  endtask

  task automatic data_phase(input int exp_beats, input int stop_after, input int ch);
    int got = 0;
    int guard = 0;
    logic [511:0] cur;
    cur = rand_beat();
    while (got < stop_after && guard < 2000) begin
      data_tvalid = ($urandom_range(3) != 0);
      data_tdata  = cur;
      out_tready  = ($urandom_range(2) != 0);
      @(negedge ap_clk);
      chk("out_valid_pass", 64'(out_tvalid), 64'(data_tvalid));
      chk("data_ready_pass", 64'(data_tready), 64'(out_tready));
      if (data_tvalid && out_tready) begin
        checks++;
        if (out_tdata !== cur) begin
          errors++;
          $display("FAIL out_tdata beat %0d: actual %0h required %0h", got, out_tdata[63:0],
                   cur[63:0]);
        end
        chk("out_tuser", 64'(out_tuser), 64'(ch));
        chk("out_tlast", 64'(out_tlast), 64'(got == exp_beats - 1));
        got++;
        cur = rand_beat();
      end
      @(posedge ap_clk); #1; guard++;
    end
    chk("beats_done", 64'(got), 64'(stop_after));
    data_tvalid = 1'b0;
    if (stop_after == exp_beats) begin
      chk("req_ready_after_data", 64'(req_tready), 64'd1);
      data_tvalid = 1'b1;
      out_tready  = 1'b1;
      #1;
      chk("no_extra_beat", {62'd0, out_tvalid, data_tready}, 64'd0);
      data_tvalid = 1'b0;
    end
  endtask

  task automatic xfer(input int len, input int ch, input bit sof, input bit eof,
                      input int exp_len);
    send_req(len, ch, sof, eof);
    get_resp(1'b1, word(exp_len, ch, sof, eof));
    if (exp_len == 0) begin
      chk("req_ready_after_zero", 64'(req_tready), 64'd1);
      data_tvalid = 1'b1;
      out_tready  = 1'b1;
      #1;
      chk("zero_grant_no_data", {62'd0, data_tready, out_tvalid}, 64'd0);
      data_tvalid = 1'b0;
      model_zero  = 1'b1;
    end else begin
      data_phase((exp_len + 63) / 64, (exp_len + 63) / 64, ch);
    end
    model_free -= (exp_len + 63) / 64;
    chk("err_zero_req", 64'(err_zero_req), 64'(model_zero));
  endtask

  task automatic ret(input int n);
    credit_ret_valid = 1'b1;
    credit_ret_beats = 11'(n);
    @(posedge ap_clk); #1;
    credit_ret_valid = 1'b0;
    if (model_free + n > BUF) begin
      model_free = BUF;
      model_ovf  = 1'b1;
    end else begin
      model_free += n;
    end
    chk("err_credit_ovf", 64'(err_credit_ovf), 64'(model_ovf));
  endtask

  task automatic stall_check(input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge ap_clk);
      chk("wait_no_resp", {62'd0, resp_tvalid, req_tready}, 64'd0);
      @(posedge ap_clk); #1;
    end
  endtask

  task automatic drain_full();
    for (int k = 0; k < 8; k++) xfer(4096, 12, 1'b0, 1'b0, 4096);
  endtask

  initial begin
    tbl[0] = '{256, 5, 1'b1, 1'b1, 256};
    tbl[1] = '{100, 2, 1'b1, 1'b0, 100};
    tbl[2] = '{8192, 7, 1'b0, 1'b1, 4096};
    tbl[3] = '{0, 9, 1'b1, 1'b1, 0};
    for (int i = 4; i < 10; i++) tbl[i] = '{4096, 1, 1'b0, 1'b0, 4096};
    tbl[10] = '{3520, 3, 1'b0, 1'b0, 3520};
    tbl[11] = '{1024, 4, 1'b1, 1'b1, 192};

    data_tvalid = 1'b1;
    out_tready  = 1'b1;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_req_tready", 64'(req_tready), 64'd0);
    chk("rst_resp_tvalid", 64'(resp_tvalid), 64'd0);
    chk("rst_resp_tdata", resp_tdata, 64'd0);
    chk("rst_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("rst_data_tready", 64'(data_tready), 64'd0);
    chk("rst_out_tlast", 64'(out_tlast), 64'd0);
    chk("rst_out_tuser", 64'(out_tuser), 64'd0);
    chk("rst_errs", {62'd0, err_zero_req, err_credit_ovf}, 64'd0);
    @(posedge ap_clk); #1;
    ap_rst_n    = 1'b1;
    data_tvalid = 1'b0;
    @(posedge ap_clk); #1;
    chk("idle_req_tready", 64'(req_tready), 64'd1);

    for (int i = 0; i < 12; i++) xfer(tbl[i].len, tbl[i].ch, tbl[i].sof, tbl[i].eof, tbl[i].exp_len);

    // No credit: request waits without a zero-length resp until one beat returns.
    send_req(64, 6, 1'b1, 1'b1);
    stall_check(20);
    ret(1);
    get_resp(1'b0, word(64, 6, 1'b1, 1'b1));
    data_phase(1, 1, 6);
    model_free -= 1;

    ret(BUF);
    ret(5);
    chk("ovf_sticky", 64'(err_credit_ovf), 64'd1);

    // Exactly BUF beats must be available after the clamp, no more.
    drain_full();
    send_req(64, 8, 1'b0, 1'b1);
    stall_check(10);
    ret(1);
    get_resp(1'b0, word(64, 8, 1'b0, 1'b1));
    data_phase(1, 1, 8);
    model_free -= 1;

    for (int t = 0; t < 25; t++) begin
      int len, ch, g, r;
      bit sof, eof;
      if (model_free < 100) ret($urandom_range(700, 100));
      if ($urandom_range(3) == 0) ret($urandom_range(20, 0));
      r = $urandom_range(9);
      if (r == 0) len = 0;
      else if (r < 5) len = $urandom_range(300, 1);
      else if (r < 8) len = $urandom_range(5000, 301);
      else len = $urandom_range(65535, 5001);
      ch  = $urandom_range(65535);
      sof = 1'($urandom_range(1));
      eof = 1'($urandom_range(1));
      g   = model_grant(len);
      xfer(len, ch, sof, eof, g);
    end

    // Reset in the middle of a burst.
    ret(BUF);
    send_req(256, 11, 1'b1, 1'b0);
    get_resp(1'b1, word(256, 11, 1'b1, 1'b0));
    data_phase(4, 2, 11);
    ap_rst_n    = 1'b0;
    data_tvalid = 1'b1;
    out_tready  = 1'b1;
    #1;
    chk("midrst_outputs", {60'd0, out_tvalid, out_tlast, req_tready, resp_tvalid}, 64'd0);
    chk("midrst_errs", {62'd0, err_zero_req, err_credit_ovf}, 64'd0);
    @(posedge ap_clk); #1;
    ap_rst_n    = 1'b1;
    data_tvalid = 1'b0;
    model_free  = BUF;
    model_zero  = 1'b0;
    model_ovf   = 1'b0;
    @(posedge ap_clk); #1;
    drain_full();
    send_req(64, 13, 1'b1, 1'b1);
    stall_check(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
